// File: rtl/elevator_pkg.sv
// Shared types and constants for the N-floor elevator controller.
// Holds the FSM state enum, the engine/direction encodings and a small helper.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_e;

    localparam logic [1:0] ENGINE_OFF  = 2'b00;
    localparam logic [1:0] ENGINE_UP   = 2'b10;
    localparam logic [1:0] ENGINE_DOWN = 2'b11;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/elevator_timer.sv
// Loadable down-counter shared by inter-floor travel and door dwell timing.
// Saturates at zero; a load takes priority over a decrement.
module elevator_timer #(
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/elevator_ctrl_n.sv
// N-floor elevator controller: latches calls, serves them in SCAN order,
// and drives registered engine/door outputs with timed travel and dwell.
module elevator_ctrl_n
    import elevator_pkg::*;
#(
    parameter int FLOORS        = 4,
    parameter int FLOOR_W       = $clog2(FLOORS),
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [FLOORS-1:0]  interior_panel,
    input  logic [FLOORS-1:0]  exterior_panel,
    output logic [1:0]         engine,
    output logic [FLOORS-1:0]  doors,
    output logic [FLOOR_W-1:0] floor,
    output logic               direction,
    output logic [FLOORS-1:0]  pending
);

    localparam int CNT_W = max_int(1, $clog2(max_int(TRAVEL_CYCLES, DOOR_CYCLES)));
    localparam logic [CNT_W-1:0] TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);

    state_e               state_q, state_d;
    logic [FLOOR_W-1:0]   floor_q, floor_d;
    logic                 dir_q, dir_d;
    logic [FLOORS-1:0]    pending_q, pending_d;
    logic [1:0]           engine_q, engine_d;
    logic [FLOORS-1:0]    doors_q, doors_d;

    logic [FLOORS-1:0]    req;
    logic                 here_req;
    logic                 above, below;
    logic [FLOOR_W-1:0]   next_floor;
    logic                 tmr_load, tmr_dec, tmr_zero;
    logic [CNT_W-1:0]     tmr_val;

    function automatic logic [FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
        logic [FLOORS-1:0] v;
        v = '0;
        for (int i = 0; i < FLOORS; i++) begin
            if (FLOOR_W'(i) == f) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [1:0] engine_of(input state_e s);
        case (s)
            MOVE_UP:   return ENGINE_UP;
            MOVE_DOWN: return ENGINE_DOWN;
            default:   return ENGINE_OFF;
        endcase
    endfunction

    elevator_timer #(.CNT_W(CNT_W)) u_timer (
        .CLK    (CLK),
        .RST    (RST),
        .load_i (tmr_load),
        .value_i(tmr_val),
        .dec_i  (tmr_dec),
        .zero_o (tmr_zero)
    );

    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (FLOOR_W'(i) > floor_q) above = above | pending_q[i];
            if (FLOOR_W'(i) < floor_q) below = below | pending_q[i];
        end
    end

    assign req        = interior_panel | exterior_panel;
    assign here_req   = req[floor_q];
    assign next_floor = (state_q == MOVE_DOWN) ? (floor_q - FLOOR_W'(1))
                                               : (floor_q + FLOOR_W'(1));

    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        dir_d     = dir_q;
        pending_d = pending_q | req;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_dec   = 1'b0;

        // A call at the car's own floor while stopped opens the door instead of latching.
        if ((state_q == IDLE) || (state_q == DOOR_OPEN)) begin
            pending_d[floor_q] = pending_q[floor_q];
        end

        case (state_q)
            IDLE: begin
                if (here_req) begin
                    state_d  = DOOR_OPEN;
                    tmr_load = 1'b1;
                    tmr_val  = DOOR_LOAD;
                end else if ((dir_q && above) || (!below && above)) begin
                    state_d  = MOVE_UP;
                    dir_d    = DIR_UP;
                    tmr_load = 1'b1;
                    tmr_val  = TRAVEL_LOAD;
                end else if (below) begin
                    state_d  = MOVE_DOWN;
                    dir_d    = DIR_DOWN;
                    tmr_load = 1'b1;
                    tmr_val  = TRAVEL_LOAD;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (tmr_zero) begin
                    floor_d  = next_floor;
                    tmr_load = 1'b1;
                    if (pending_q[next_floor]) begin
                        pending_d[next_floor] = 1'b0;
                        state_d = DOOR_OPEN;
                        tmr_val = DOOR_LOAD;
                    end else begin
                        tmr_val = TRAVEL_LOAD;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            DOOR_OPEN: begin
                if (here_req) begin
                    tmr_load = 1'b1;
                    tmr_val  = DOOR_LOAD;
                end else if (tmr_zero) begin
                    state_d = IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        engine_d = engine_of(state_d);
        doors_d  = (state_d == DOOR_OPEN) ? onehot(floor_d) : '0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            floor_q   <= '0;
            dir_q     <= DIR_UP;
            pending_q <= '0;
            engine_q  <= ENGINE_OFF;
            doors_q   <= '0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_q     <= dir_d;
            pending_q <= pending_d;
            engine_q  <= engine_d;
            doors_q   <= doors_d;
        end
    end

    assign engine    = engine_q;
    assign doors     = doors_q;
    assign floor     = floor_q;
    assign direction = dir_q;
    assign pending   = pending_q;

endmodule

// File: doc/elevator_ctrl_n.md
Name: elevator_ctrl_n

Overview:
- Parametrised N-floor elevator controller; successor to the fixed 3-floor movement controller.
- Latches interior and exterior calls into a pending-request vector and serves them in SCAN order: keep the current direction while requests lie ahead, otherwise reverse.
- Times inter-floor travel and door dwell with internal counters.
- Drives the engine and one-hot door outputs; sits between the panel debouncers and the motor/door drivers.

Parameters:
- FLOORS, 4, number of floors (2..16); floor 0 is the lowest.
- FLOOR_W, $clog2(FLOORS), width of the floor index.
- TRAVEL_CYCLES, 8, clock cycles to move one floor (>=2).
- DOOR_CYCLES, 4, clock cycles the door stays open (>=1).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- interior_panel  in  FLOORS  car call buttons, bit i = floor i, level or pulse.
- exterior_panel  in  FLOORS  hall call buttons, bit i = floor i.
- engine  out  2  00 off, 10 up, 11 down.
- doors  out  FLOORS  one-hot open door, 1 = open.
- floor  out  FLOOR_W  current car floor.
- direction  out  1  1 up, 0 down.
- pending  out  FLOORS  latched, unserved requests.

Behaviour:
- Reset (asynchronous, RST=0):
  - state=IDLE, floor=0, direction=1, pending=0, engine=00, doors=0, counter=0.
  - Reset mid-move or mid-dwell aborts immediately; all requests are lost.
- All outputs are registered. engine is a function of state: MOVE_UP=10, MOVE_DOWN=11, otherwise 00. doors = onehot(floor) only in DOOR_OPEN.
- Request capture, every cycle:
  - req = interior_panel | exterior_panel.
  - pending <= pending | req, except the bit at floor when state is IDLE or DOOR_OPEN. That bit opens the door (or restarts the dwell counter in DOOR_OPEN) and is not latched.
  - Bits are never cleared by input release; they clear only on service.
- Definitions: above = |pending[FLOORS-1:floor+1]; below = |pending[floor-1:0].
- State machine (package enum): IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- IDLE:
  - req[floor] -> DOOR_OPEN next edge, counter=DOOR_CYCLES-1.
  - else if (direction && above) || (!below && above) -> MOVE_UP, direction=1.
  - else if below -> MOVE_DOWN, direction=0.
  - else stay IDLE. Decision latency: one cycle after the pending bit is visible.
- MOVE_UP/MOVE_DOWN:
  - Entry loads counter=TRAVEL_CYCLES-1; decrement each cycle.
  - At counter==0: floor +/-1.
    - If pending[new floor]: clear it, go to DOOR_OPEN, counter=DOOR_CYCLES-1.
    - Otherwise reload the counter and keep moving. A request always remains ahead, because pending bits only clear on arrival.
  - Requests for floors passed mid-segment are served later, after reversal.
- DOOR_OPEN: decrement the counter each cycle; at 0 go to IDLE. IDLE resolves continue/reverse on the following edge.
- Boundaries:
  - At floor FLOORS-1, above=0; at floor 0, below=0. Never move beyond the ends, so floor never wraps.
  - Simultaneous requests above and below in IDLE: the current direction wins.
  - All-ones request while IDLE at floor 0: open the door at 0 first, then sweep upward stopping at every floor.

Decomposition:
- elevator_pkg holds:
  - state enum;
  - ENGINE_OFF=2'b00, ENGINE_UP=2'b10, ENGINE_DOWN=2'b11;
  - DIR_UP=1, DIR_DOWN=0.
- One sub-module, elevator_timer:
  - loadable down-counter with load/value/zero outputs, width $clog2(max(TRAVEL_CYCLES,DOOR_CYCLES));
  - shared by travel and dwell, since only one is active at a time.

Test Plan:
- Reset: hold RST=0 -> floor=0, engine=00, doors=0000, pending=0000, direction=1. Release; with no input, the outputs stay unchanged.
- Idle at floor 0, pulse interior_panel=0001 -> next edge doors=0001 for exactly 4 cycles, then 0000; pending stays 0000; engine stays 00.
- Idle at 0, pulse exterior_panel=1000:
  - pending=1000, then engine=10 on the next edge.
  - floor increments every 8 cycles with no stops at 1 or 2.
  - At floor 3: engine=00, doors=1000 for 4 cycles, pending=0000.
- Moving up from 0 toward 3, pulse interior_panel=0010 within the first 8 cycles -> stops at floor 1 with doors=0010, then resumes to 3.
- Moving up toward 3, pulse interior_panel=0001 -> serviced after floor 3: direction=0, engine=11, door at 0.
- Idle at floor 2 with direction=1, requests 0010 and 1000 latched in the same cycle -> floor 3 served first, then floor 1.
- Reset mid-move: RST low while engine=10 -> same cycle outputs go to reset values and pending=0000.
